// File: rtl/seg7_scan_display.sv
// Multiplexed 7-segment driver: sequential binary-to-BCD (shift-add-3) plus digit scanning.
// Optional LEADING_ZERO_BLANK_EN blanks zero digits above the most significant non-zero digit.
module seg7_scan_display #(
  parameter int unsigned NUM_DIGITS  = 4,
  parameter int unsigned BIN_W       = 14,
  parameter int unsigned REFRESH_DIV = 100000,
  parameter bit          SEG_ACT_LOW = 1'b0,
  parameter bit          AN_ACT_LOW  = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  value_valid,
  input  logic [BIN_W-1:0]      value,
  output logic                  value_ready,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic [NUM_DIGITS-1:0] an,
  output logic                  overflow
);

  // Decimal digits needed to hold the largest BIN_W-bit value.
  function automatic int unsigned calc_bcd_digits(input int unsigned w);
    longint unsigned m;
    int unsigned     n;
    m = 64'd1 << w;
    m = m - 64'd1;
    n = 1;
    while (m >= 64'd10) begin
      m = m / 64'd10;
      n++;
    end
    return n;
  endfunction

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1111110;
      4'd1:    s = 7'b0110000;
      4'd2:    s = 7'b1101101;
      4'd3:    s = 7'b1111001;
      4'd4:    s = 7'b0110011;
      4'd5:    s = 7'b1011011;
      4'd6:    s = 7'b1011111;
      4'd7:    s = 7'b1110000;
      4'd8:    s = 7'b1111111;
      4'd9:    s = 7'b1111011;
      default: s = 7'b0000001;
    endcase
    return s;
  endfunction

  localparam int unsigned BinDigits = calc_bcd_digits(BIN_W);
  localparam int unsigned BcdDigits = (BinDigits > NUM_DIGITS) ? BinDigits : NUM_DIGITS;
  localparam int unsigned BcdW      = 4 * BcdDigits;
  localparam int unsigned StepW     = $clog2(BIN_W + 1);
  localparam int unsigned CntW      = $clog2(REFRESH_DIV);
  localparam int unsigned IdxW      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [6:0]  SegDash   = 7'b0000001;

  typedef enum logic [0:0] {StIdle, StConvert} state_e;

  state_e                    state_q, state_d;
  logic [BIN_W-1:0]          bin_q, bin_d;
  logic [BcdW-1:0]           bcd_q, bcd_d;
  logic [StepW-1:0]          step_q, step_d;
  logic [4*NUM_DIGITS-1:0]   digit_q, digit_d;
  logic                      ovf_q, ovf_d;
  logic [CntW-1:0]           ref_cnt_q, ref_cnt_d;
  logic [IdxW-1:0]           scan_idx_q, scan_idx_d;
  logic [6:0]                seg_q, seg_d;
  logic [NUM_DIGITS-1:0]     an_q, an_d;

  logic [BcdW-1:0]           bcd_adj;
  logic [BcdW+BIN_W-1:0]     shifted;
  logic                      high_nz;

  // Conversion FSM
  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    bcd_d   = bcd_q;
    step_d  = step_q;
    digit_d = digit_q;
    ovf_d   = ovf_q;
    bcd_adj = bcd_q;
    for (int i = 0; i < int'(BcdDigits); i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
    shifted = {bcd_adj, bin_q} << 1;
    // Any non-zero digit beyond the displayed ones means the value does not fit.
    high_nz = 1'b0;
    for (int i = int'(NUM_DIGITS); i < int'(BcdDigits); i++) begin
      high_nz = high_nz | (bcd_q[4*i +: 4] != 4'd0);
    end
    case (state_q)
      StIdle: begin
        if (value_valid) begin
          state_d = StConvert;
          bin_d   = value;
          bcd_d   = '0;
          step_d  = '0;
        end
      end
      StConvert: begin
        if (step_q == StepW'(BIN_W)) begin
          digit_d = bcd_q[4*NUM_DIGITS-1:0];
          ovf_d   = high_nz;
          state_d = StIdle;
        end else begin
          {bcd_d, bin_d} = shifted;
          step_d         = step_q + StepW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  logic [NUM_DIGITS-1:0] blank_vec;
  logic [NUM_DIGITS-1:0] an_onehot;
  logic [3:0]            cur_digit;
  logic                  cur_blank;
  logic                  nz_seen;
  logic [6:0]            seg_raw;

  // Scan and output registers
  always_comb begin
    ref_cnt_d  = ref_cnt_q + CntW'(1);
    scan_idx_d = scan_idx_q;
    if (ref_cnt_q == CntW'(REFRESH_DIV - 1)) begin
      ref_cnt_d  = '0;
      scan_idx_d = (scan_idx_q == IdxW'(NUM_DIGITS - 1)) ? '0 : scan_idx_q + IdxW'(1);
    end

    blank_vec = '0;
    nz_seen   = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
    for (int i = int'(NUM_DIGITS) - 1; i >= 1; i--) begin
      nz_seen      = nz_seen | (digit_q[4*i +: 4] != 4'd0);
      blank_vec[i] = ~nz_seen;
    end
`endif

    an_onehot = '0;
    cur_digit = 4'd0;
    cur_blank = 1'b0;
    for (int i = 0; i < int'(NUM_DIGITS); i++) begin
      if (scan_idx_q == IdxW'(i)) begin
        an_onehot[i] = 1'b1;
        cur_digit    = digit_q[4*i +: 4];
        cur_blank    = blank_vec[i];
      end
    end

    if (ovf_q)          seg_raw = SegDash;
    else if (cur_blank) seg_raw = 7'b0000000;
    else                seg_raw = seg_decode(cur_digit);

    seg_d = seg_raw ^ {7{SEG_ACT_LOW}};
    an_d  = an_onehot ^ {NUM_DIGITS{AN_ACT_LOW}};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      bin_q      <= '0;
      bcd_q      <= '0;
      step_q     <= '0;
      digit_q    <= '0;
      ovf_q      <= 1'b0;
      ref_cnt_q  <= '0;
      scan_idx_q <= '0;
      seg_q      <= {7{SEG_ACT_LOW}};
      an_q       <= {NUM_DIGITS{AN_ACT_LOW}};
    end else begin
      state_q    <= state_d;
      bin_q      <= bin_d;
      bcd_q      <= bcd_d;
      step_q     <= step_d;
      digit_q    <= digit_d;
      ovf_q      <= ovf_d;
      ref_cnt_q  <= ref_cnt_d;
      scan_idx_q <= scan_idx_d;
      seg_q      <= seg_d;
      an_q       <= an_d;
    end
  end

  assign value_ready = (state_q == StIdle);
  assign seg         = seg_q;
  assign an          = an_q;
  assign dp          = SEG_ACT_LOW;
  assign overflow    = ovf_q;

endmodule
